// File: rtl/cpu_param.sv
// Parametrised single-cycle CPU: 16 x DW register file, ALU with zero flag, return stack
// with overflow/underflow trap, OUT port and HALT. Instruction memory is external.
// state   | meaning
// ST_RUN  | fetching and executing one instruction per cycle
// ST_HALT | stopped by HALT or stack error; only reset leaves
module cpu_param #(
    parameter int DW     = 8,
    parameter int PCW    = 10,
    parameter int SDEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    output logic [PCW-1:0] pc,
    input  logic [15:0]    instr,
    output logic [DW-1:0]  out_data,
    output logic           out_valid,
    output logic           halted,
    output logic           stack_err
);
    localparam int SAW = $clog2(SDEPTH);
    localparam int SPW = SAW + 1;

    typedef enum logic {ST_RUN, ST_HALT} state_t;
    state_t state, state_nxt;

    logic [DW-1:0]  regs [16];
    logic [PCW-1:0] stack_mem [SDEPTH];
    logic [SPW-1:0] sp;
    logic           z;

    logic [3:0]     op, rd, ra, rb;
    logic [DW-1:0]  a_val, b_val, alu_res, wr_data, imm_ext;
    logic [PCW-1:0] addr, pc_inc, pc_nxt, pop_val;
    logic           wr_en, z_nxt, push, pop, err, out_fire;

    assign op      = instr[15:12];
    assign rd      = instr[11:8];
    assign ra      = instr[7:4];
    assign rb      = instr[3:0];
    assign addr    = instr[PCW-1:0];
    assign imm_ext = DW'(instr[7:0]);
    assign a_val   = regs[ra];
    assign b_val   = regs[rb];
    assign pc_inc  = pc + PCW'(1);
    assign pop_val = stack_mem[SAW'(sp - SPW'(1))];
    assign halted  = (state == ST_HALT);

    always_comb begin
        alu_res = '0;
        case (op)
            4'd1:    alu_res = a_val + b_val;
            4'd2:    alu_res = a_val - b_val;
            4'd3:    alu_res = a_val & b_val;
            4'd4:    alu_res = a_val | b_val;
            4'd5:    alu_res = a_val ^ b_val;
            4'd6:    alu_res = ~a_val;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_inc;
        wr_en     = 1'b0;
        wr_data   = alu_res;
        z_nxt     = z;
        push      = 1'b0;
        pop       = 1'b0;
        err       = 1'b0;
        out_fire  = 1'b0;
        if (state == ST_HALT) begin
            pc_nxt = pc;
        end else begin
            case (op)
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                    wr_en = 1'b1;
                    z_nxt = (alu_res == '0);
                end
                4'd8: begin
                    wr_en   = 1'b1;
                    wr_data = imm_ext;
                end
                4'd9:  pc_nxt = addr;
                4'd10: if (z) pc_nxt = addr;
                4'd11: if (!z) pc_nxt = addr;
                4'd12: begin
                    if (sp == SPW'(SDEPTH)) begin
                        err       = 1'b1;
                        state_nxt = ST_HALT;
                        pc_nxt    = pc;
                    end else begin
                        push   = 1'b1;
                        pc_nxt = addr;
                    end
                end
                4'd13: begin
                    if (sp == '0) begin
                        err       = 1'b1;
                        state_nxt = ST_HALT;
                        pc_nxt    = pc;
                    end else begin
                        pop    = 1'b1;
                        pc_nxt = pop_val;
                    end
                end
                4'd14: out_fire = 1'b1;
                4'd15: begin
                    state_nxt = ST_HALT;
                    pc_nxt    = pc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= '0;
            z         <= 1'b0;
            sp        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            stack_err <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            pc        <= pc_nxt;
            z         <= z_nxt;
            out_valid <= out_fire;
            if (out_fire) out_data <= a_val;
            if (err) stack_err <= 1'b1;
            // R0 is never written, so its reset value keeps it reading zero
            if (wr_en && rd != 4'd0) regs[rd] <= wr_data;
            if (push)     sp <= sp + SPW'(1);
            else if (pop) sp <= sp - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) stack_mem[sp[SAW-1:0]] <= pc_inc;
    end
endmodule

// File: tb/tb_cpu_param.sv
// Bench for cpu_param (DW=8, PCW=5, SDEPTH=4): an instruction-level model predicts pc,
// halt and error each cycle; OUT values go through a queue checked by a separate monitor.
module tb_cpu_param;
    localparam int DW = 8, PCW = 5, SDEPTH = 4;
    localparam int PCMOD = 1 << PCW;

    logic           clk, reset;
    logic [PCW-1:0] pc;
    logic [15:0]    instr;
    logic [DW-1:0]  out_data;
    logic           out_valid, halted, stack_err;

    logic [15:0] prog [PCMOD];
    assign instr = prog[pc];

    cpu_param #(.DW(DW), .PCW(PCW), .SDEPTH(SDEPTH)) dut (
        .clk(clk), .reset(reset), .pc(pc), .instr(instr),
        .out_data(out_data), .out_valid(out_valid),
        .halted(halted), .stack_err(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int unsigned exp_q[$];

    int unsigned m_r [16];
    int unsigned m_stk [SDEPTH];
    int          m_sp, m_pc;
    bit          m_z, m_halt, m_err;

    task automatic chk(string name, int unsigned act, int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] alu(int op, int rd, int ra, int rb);
        return 16'((op << 12) | (rd << 8) | (ra << 4) | rb);
    endfunction
    function automatic logic [15:0] li(int rd, int imm);
        return 16'((8 << 12) | (rd << 8) | (imm & 255));
    endfunction
    function automatic logic [15:0] jmp(int op, int a);
        return 16'((op << 12) | a);
    endfunction

    task automatic m_reset();
        foreach (m_r[i]) m_r[i] = 0;
        m_z = 0; m_sp = 0; m_pc = 0; m_halt = 0; m_err = 0;
    endtask

    task automatic m_step();
        int unsigned ins, a, b, res;
        int op, rd, ra, rb, nxt, tgt;
        if (m_halt) return;
        ins = prog[m_pc];
        op = ins >> 12; rd = (ins >> 8) & 15; ra = (ins >> 4) & 15; rb = ins & 15;
        tgt = ins % PCMOD;
        a = m_r[ra]; b = m_r[rb];
        nxt = (m_pc + 1) % PCMOD;
        res = 0;
        case (op)
            1: res = (a + b) % 256;
            2: res = (a + 256 - b) % 256;
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: res = 255 - a;
            default: res = 0;
        endcase
        if (op >= 1 && op <= 6) begin
            if (rd != 0) m_r[rd] = res;
            m_z = (res == 0);
        end
        case (op)
            8:  if (rd != 0) m_r[rd] = ins & 255;
            9:  nxt = tgt;
            10: if (m_z) nxt = tgt;
            11: if (!m_z) nxt = tgt;
            12: if (m_sp == SDEPTH) begin
                    m_err = 1; m_halt = 1; nxt = m_pc;
                end else begin
                    m_stk[m_sp] = (m_pc + 1) % PCMOD; m_sp++; nxt = tgt;
                end
            13: if (m_sp == 0) begin
                    m_err = 1; m_halt = 1; nxt = m_pc;
                end else begin
                    m_sp--; nxt = m_stk[m_sp];
                end
            14: exp_q.push_back(a);
            15: begin m_halt = 1; nxt = m_pc; end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    // Called at a negedge; returns at the negedge following the reset edge.
    task automatic do_reset();
        chk("pending_outputs", exp_q.size(), 0);
        exp_q.delete();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        chk("rst_pc", pc, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_halted", halted, 0);
        chk("rst_stack_err", stack_err, 0);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            chk("pc", pc, m_pc);
            chk("halted", halted, m_halt);
            chk("stack_err", stack_err, m_err);
            m_step();
            @(negedge clk);
        end
    endtask

    task automatic clear_prog();
        foreach (prog[i]) prog[i] = 16'h0000;
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #2;
            if (out_valid) begin
                if (exp_q.size() == 0) chk("out_valid_unexpected", out_valid, 0);
                else                   chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin : stim
        reset = 1'b1;
        clear_prog();
        @(negedge clk);

        // arithmetic wrap and zero flag
        clear_prog();
        prog[0] = li(1, 200); prog[1] = li(2, 100); prog[2] = alu(1, 3, 1, 2);
        prog[3] = alu(14, 0, 3, 0); prog[4] = alu(2, 4, 1, 1); prog[5] = jmp(10, 8);
        prog[6] = alu(14, 0, 1, 0); prog[8] = alu(14, 0, 2, 0); prog[9] = jmp(15, 0);
        do_reset();
        run(12);

        // countdown loop
        clear_prog();
        prog[0] = li(1, 3); prog[1] = li(5, 1); prog[2] = alu(2, 1, 1, 5);
        prog[3] = jmp(11, 2); prog[4] = alu(14, 0, 1, 0); prog[5] = jmp(15, 0);
        do_reset();
        run(14);

        // nested calls, three deep
        clear_prog();
        prog[0] = li(1, 11); prog[1] = li(2, 22); prog[2] = li(3, 33); prog[3] = jmp(12, 8);
        prog[4] = li(6, 99); prog[5] = alu(14, 0, 6, 0); prog[6] = jmp(15, 0);
        prog[8] = alu(14, 0, 1, 0); prog[9] = jmp(12, 12); prog[10] = jmp(13, 0);
        prog[12] = alu(14, 0, 2, 0); prog[13] = jmp(12, 16); prog[14] = jmp(13, 0);
        prog[16] = alu(14, 0, 3, 0); prog[17] = jmp(13, 0);
        do_reset();
        run(20);

        // recursive call overflows on the fifth CALL
        clear_prog();
        prog[0] = li(1, 9); prog[1] = jmp(12, 1); prog[2] = alu(14, 0, 1, 0);
        do_reset();
        run(12);

        // underflow at reset
        clear_prog();
        prog[0] = jmp(13, 0);
        do_reset();
        run(5);

        // HALT at pc 5, then reset mid-run and rerun
        clear_prog();
        prog[5] = jmp(15, 0); prog[6] = li(1, 1);
        do_reset();
        run(10);
        do_reset();
        run(3);
        do_reset();
        run(9);

        // pc wrap and R0 hardwired to zero
        clear_prog();
        prog[0] = li(0, 7); prog[1] = alu(14, 0, 0, 0);
        do_reset();
        run(70);

        // random programs with random reset points
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < PCMOD; k++) begin
                int op;
                op = $urandom_range(0, 15);
                if (op == 15 && $urandom_range(0, 3) != 0) op = 14;
                prog[k] = 16'((op << 12) | ($urandom & 16'h0FFF));
            end
            do_reset();
            run($urandom_range(5, 40));
            do_reset();
            run(30);
        end

        chk("pending_outputs", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_param.md
# cpu_param

Parametrised single-cycle CPU: the next generation of the team's monocycle processor. It generalises data width, program-counter width and return-stack depth, and adds an output port, a halt state and return-stack overflow/underflow detection. Instruction memory sits outside the block: the core drives `pc` and receives the instruction word combinationally. Intended as the top of the next teaching/lab processor, with the register file, ALU, zero flag and call stack all inside one block.

## Interface
- `DW`, 8: data/register width (4..32).
- `PCW`, 10: program counter width (4..12).
- `SDEPTH`, 8: return-stack depth in entries (power of 2, ≥2).
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `pc`  out  PCW: address of the current instruction.
- `instr`  in  16: instruction at `pc`, valid combinationally in the same cycle.
- `out_data`  out  DW: last value written by OUT.
- `out_valid`  out  1: one-cycle pulse, high in the cycle after an OUT executes.
- `halted`  out  1: core stopped (HALT or stack error).
- `stack_err`  out  1: sticky; set on overflow or underflow.

## Operation
- 16 registers R0..R15 of DW bits. R0 always reads 0 and ignores writes.
- Fields: op=`instr[15:12]`, rd=`[11:8]`, ra=`[7:4]`, rb=`[3:0]`, imm8=`[7:0]`, addr=`instr[PCW-1:0]`.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd=ra op rb.
  - 6 NOT: rd=~ra.
  - 8 LI: rd=imm8, zero-extended, or truncated to DW if DW<8.
  - 9 JMP addr. 10 JZ addr (if z=1). 11 JNZ addr (if z=0).
  - 12 CALL addr. 13 RET.
  - 14 OUT: out_data=R[ra].
  - 15 HALT.
  - 7: reserved, behaves as NOP.
- ALU arithmetic is modulo 2^DW. ALU ops 1..6 update z=(result==0). No other instruction touches z.
- Next pc:
  - Default pc+1, wrapping from 2^PCW−1 to 0.
  - Taken jump or CALL: addr.
  - RET: popped value.
  - Not-taken JZ/JNZ: pc+1.
- Return stack: SDEPTH entries, pointer sp counts 0..SDEPTH.
  - CALL with sp<SDEPTH: stack[sp]=pc+1 (wrapped), sp+1.
  - CALL with sp==SDEPTH: overflow. No push, pc holds, `stack_err`=1, `halted`=1.
  - RET with sp>0: pc=stack[sp−1], sp−1.
  - RET with sp==0: underflow. Same error and halt as overflow.
- HALT: `halted`=1 and pc holds at the HALT's address.
- While halted: no register, z, sp, pc or output updates; `instr` is ignored. Only `reset` leaves halt.
- Register write from an instruction at `pc` completes at that cycle's rising edge. The next instruction sees the new value; there are no hazards.

## Timing
- One instruction per cycle; instruction fetch is combinational. Effects appear at the next rising edge.
- Reset values (sampled on clk with `reset`=1):
  - pc=0, R1..R15=0, z=0, sp=0.
  - out_data=0, out_valid=0, halted=0, stack_err=0.
  - `reset` overrides any instruction in the same cycle, including a CALL/RET error.
- `out_valid` is registered: high for exactly the cycle after each OUT, with `out_data` updated on the same edge. Back-to-back OUTs keep `out_valid` high for consecutive cycles.
- `halted` and `stack_err` assert on the edge that executes the faulting or HALT instruction.
- Reset mid-program clears everything. Execution restarts at pc=0 on the first cycle with `reset`=0.

## Test plan
- Arithmetic, DW=8: LI R1,200; LI R2,100; ADD R3,R1,R2; OUT R3 -> out_data=44 (300 mod 256), z=0. Then SUB R4,R1,R1 -> z=1.
- Branching: LI R1,3; loop {SUB R1,R1,R5 with R5=1; JNZ loop}; OUT R1 -> JNZ taken twice then falls through, out_data=0, total cycle count exact.
- Call/return: nested CALLs 3 deep, each callee OUTs a distinct value then RETs -> outputs appear in program order, pc returns to each caller's address+1, sp ends at 0.
- Overflow, SDEPTH=4: recursive CALL to self -> fifth CALL sets stack_err=1 and halted=1, pc frozen at that CALL, sp=4. Subsequent cycles show no register changes.
- Underflow and halt: RET at reset -> stack_err=1, halted=1, pc=0. Separately, HALT at pc=5 -> pc stays 5, stack_err=0. Asserting `reset` for one cycle -> all outputs back to reset values, execution resumes from pc=0.
- Wrap and R0: PCW=4, NOPs through pc=15 -> next pc=0. LI R0,7; OUT R0 -> out_data=0.
